// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA effect chain: 640x480@60 timing,
// effect mode encodings and the TinyVGA Pmod bit layout.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'd0,
    MODE_NOISE   = 2'd1,
    MODE_TWINKLE = 2'd2,
    MODE_BLANK   = 2'd3
  } mode_e;

  // TinyVGA Pmod byte: {hsync, b0, g0, r0, vsync, b1, g1, r1}
  localparam int VGA_HSYNC_BIT = 7;
  localparam int VGA_B0_BIT    = 6;
  localparam int VGA_G0_BIT    = 5;
  localparam int VGA_R0_BIT    = 4;
  localparam int VGA_VSYNC_BIT = 3;
  localparam int VGA_B1_BIT    = 2;
  localparam int VGA_G1_BIT    = 1;
  localparam int VGA_R1_BIT    = 0;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  // Star iff rnd >= 256 - 2^d; nine bits so d=0 yields a threshold of 255.
  function automatic logic is_star(logic [7:0] rnd, logic [2:0] d);
    logic [8:0] thr;
    thr = 9'd256 - (9'd1 << d);
    return {1'b0, rnd} >= thr;
  endfunction

  function automatic logic [7:0] pack_tinyvga(logic hsync_n, logic vsync_n, rgb_t c);
    logic [7:0] v;
    v                = '0;
    v[VGA_HSYNC_BIT] = hsync_n;
    v[VGA_B0_BIT]    = c.b[0];
    v[VGA_G0_BIT]    = c.g[0];
    v[VGA_R0_BIT]    = c.r[0];
    v[VGA_VSYNC_BIT] = vsync_n;
    v[VGA_B1_BIT]    = c.b[1];
    v[VGA_G1_BIT]    = c.g[1];
    v[VGA_R1_BIT]    = c.r[1];
    return v;
  endfunction

endpackage

// File: rtl/vga_starfield_renderer_if.sv
// Link between the renderer and the 8-bit PRNG stage: one byte per cycle,
// with step and reseed strobes driven by the renderer.
interface vga_starfield_renderer_if;
  logic [7:0] rnd_in;
  logic       rnd_advance;
  logic       rnd_reseed;

  // Renderer side.
  modport master (
    input  rnd_in,
    output rnd_advance,
    output rnd_reseed
  );

  // PRNG side.
  modport slave (
    output rnd_in,
    input  rnd_advance,
    input  rnd_reseed
  );
endinterface

// File: rtl/vga_timing.sv
// Raster counters, frame counter and sync/active decode; shared by any
// effect that needs a pixel position.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       active,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       frame_end,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        v_cnt <= v_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hsync_n   = !((h_cnt >= H_SYNC_LO) && (h_cnt <= H_SYNC_HI));
  assign vsync_n   = !((v_cnt >= V_SYNC_LO) && (v_cnt <= V_SYNC_HI));
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_starfield_renderer.sv
// Starfield / twinkle / noise renderer: one PRNG byte per active pixel,
// registered TinyVGA output, and PRNG control so static frames repeat.
module vga_starfield_renderer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic                            clk,
  input  logic                            rst_n,
  vga_starfield_renderer_if.master        prng,
  input  logic [2:0]                      density,
  input  logic [1:0]                      mode,
  output logic [7:0]                      vga_out,
  output logic [7:0]                      frame_cnt
);

  logic  active;
  logic  hsync_n;
  logic  vsync_n;
  logic  frame_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (active),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .frame_end (frame_end),
    .frame_cnt (frame_cnt)
  );

  // Effect controls only change between frames so a frame is never torn.
  mode_e      mode_q;
  logic [2:0] dens_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_STATIC;
      dens_q <= '0;
    end else if (frame_end) begin
      mode_q <= mode_e'(mode);
      dens_q <= density;
    end
  end

  logic       star;
  logic [1:0] lvl_static;
  logic [1:0] lvl_twinkle;
  rgb_t       colour;

  assign star        = is_star(prng.rnd_in, dens_q);
  assign lvl_static  = prng.rnd_in[1:0] | 2'b01;
  assign lvl_twinkle = prng.rnd_in[1:0] ^ frame_cnt[3:2];

  // NOTE: colour gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    colour = '0;
    if (active) begin
      unique case (mode_q)
        MODE_STATIC: begin
          if (star) colour = '{r: lvl_static, g: lvl_static, b: lvl_static};
        end
        MODE_NOISE: begin
          colour = '{r: prng.rnd_in[1:0], g: prng.rnd_in[3:2], b: prng.rnd_in[5:4]};
        end
        MODE_TWINKLE: begin
          if (star) colour = '{r: lvl_twinkle, g: lvl_twinkle, b: lvl_twinkle};
        end
        MODE_BLANK: colour = '0;
      endcase
    end
  end

  // Reseeding at the last blanking cycle makes pixel (0,0) see the first
  // post-seed byte; the policy follows the shadow that is ending its frame.
  assign prng.rnd_advance = (mode_q == MODE_NOISE) || active;
  assign prng.rnd_reseed  = frame_end &&
                            ((mode_q == MODE_STATIC) || (mode_q == MODE_TWINKLE));

  // Syncs share the output register with colour so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_out <= pack_tinyvga(1'b1, 1'b1, '0);
    end else begin
      vga_out <= pack_tinyvga(hsync_n, vsync_n, colour);
    end
  end

endmodule

// File: tb/tb_vga_starfield_renderer.sv
// Bench for vga_starfield_renderer: a reduced-timing instance checked cycle by
// cycle against a raster model, plus a full 640x480 instance for line timing.
module tb_vga_starfield_renderer;

  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rnd = 8'h00;
  logic [2:0] density = 3'd0;
  logic [1:0] mode = 2'd0;
  logic [7:0] vga_out, frame_cnt;
  logic [7:0] vga_out_full, frame_cnt_full;

  vga_starfield_renderer_if pif ();
  vga_starfield_renderer_if pif_full ();
  assign pif.rnd_in      = rnd;
  assign pif_full.rnd_in = rnd;

  always #5 clk = ~clk;

  vga_starfield_renderer #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prng      (pif),
    .density   (density),
    .mode      (mode),
    .vga_out   (vga_out),
    .frame_cnt (frame_cnt)
  );

  vga_starfield_renderer dut_full (
    .clk       (clk),
    .rst_n     (rst_n),
    .prng      (pif_full),
    .density   (density),
    .mode      (mode),
    .vga_out   (vga_out_full),
    .frame_cnt (frame_cnt_full)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         t;
  int         sh_mode, sh_d;
  logic [7:0] exp_vga;
  bit         prev_active;

  // Reference pixel for raster position (h,v), straight from the colour rules.
  function automatic logic [7:0] model_pixel(int h, int v, int m, int d, int r, int fr);
    int  hs, vs, cr, cg, cb;
    bit  act, star;
    hs   = (h >= HA + HF && h < HA + HF + HS) ? 0 : 1;
    vs   = (v >= VA + VF && v < VA + VF + VS) ? 0 : 1;
    act  = (h < HA) && (v < VA);
    star = r >= 256 - (1 << d);
    cr = 0; cg = 0; cb = 0;
    if (act) begin
      case (m)
        0: if (star) begin cr = (r % 4) | 1; cg = cr; cb = cr; end
        1: begin cr = r % 4; cg = (r / 4) % 4; cb = (r / 16) % 4; end
        2: if (star) begin cr = (r % 4) ^ ((fr / 4) % 4); cg = cr; cb = cr; end
        default: ;
      endcase
    end
    return {hs[0], cb[0], cg[0], cr[0], vs[0], cb[1], cg[1], cr[1]};
  endfunction

  function automatic bit model_adv(int tt, int m);
    return (m == 1) || (((tt % HT) < HA) && (((tt / HT) % VT) < VA));
  endfunction

  function automatic bit model_reseed(int tt, int m);
    return ((tt % FT) == FT - 1) && (m == 0 || m == 2);
  endfunction

  // Advance model and DUT by one clock; exp_vga is the output the DUT must
  // show afterwards for the state just left.
  task automatic step();
    int h, v, fr;
    h  = t % HT;
    v  = (t / HT) % VT;
    fr = (t / FT) % 256;
    exp_vga     = model_pixel(h, v, sh_mode, sh_d, int'(rnd), fr);
    prev_active = (h < HA) && (v < VA);
    if (h == HT - 1 && v == VT - 1) begin
      sh_mode = int'(mode);
      sh_d    = int'(density);
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  // At least one clock, then stop with the next state at (0,0).
  task automatic run_to_boundary(input bit random_rnd);
    step();
    for (int i = 0; i < FT && (t % FT) != 0; i++) begin
      if (random_rnd) rnd = 8'($urandom);
      step();
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    t       = 0;
    sh_mode = 0;
    sh_d    = 0;
  endtask

  task automatic test_reset();
    mode = 2'd0; density = 3'd0; rnd = 8'($urandom);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (vga_out !== 8'h88) begin n_err++; $display("FAIL reset_vga got=%h want=88", vga_out); end
    n_cmp++;
    if (vga_out_full !== 8'h88) begin n_err++; $display("FAIL reset_vga_full got=%h want=88", vga_out_full); end
    n_cmp++;
    if (frame_cnt !== 8'h00 || frame_cnt_full !== 8'h00) begin
      n_err++; $display("FAIL reset_frame_cnt got=%h/%h want=00", frame_cnt, frame_cnt_full);
    end
    n_cmp++;
    if (pif.rnd_advance !== 1'b1 || pif.rnd_reseed !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes adv=%b res=%b want adv=1 res=0", pif.rnd_advance, pif.rnd_reseed);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (vga_out !== 8'h88) begin n_err++; $display("FAIL reset_hold got=%h want=88", vga_out); end
    release_reset();
  endtask

  // Mode 0 from reset; full-size instance checked for the 640x480 line timing.
  task automatic test_hsync_full();
    int first_fall, hs_low, vs_low, bad;
    first_fall = -1; hs_low = 0; vs_low = 0; bad = 0;
    density = 3'($urandom_range(0, 7));
    for (int k = 1; k <= 2400; k++) begin
      rnd = 8'($urandom);
      step();
      if (vga_out !== exp_vga) begin
        bad++;
        if (bad < 5) $display("FAIL line_pixel t=%0d got=%h want=%h", t, vga_out, exp_vga);
      end
      if (!vga_out_full[7]) begin
        hs_low++;
        if (first_fall < 0) first_fall = k;
      end
      if (!vga_out_full[3]) vs_low++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL line_pixels bad=%0d want=0", bad); end
    n_cmp++;
    if (first_fall != 657) begin n_err++; $display("FAIL hsync_first_fall got=%0d want=657", first_fall); end
    n_cmp++;
    if (hs_low != 3 * 96) begin n_err++; $display("FAIL hsync_low_count got=%0d want=%0d", hs_low, 3 * 96); end
    n_cmp++;
    if (vs_low != 0) begin n_err++; $display("FAIL vsync_early got=%0d want=0", vs_low); end
  endtask

  task automatic test_full_frame(input int m);
    int adv_cnt, res_cnt, vs_cnt, bad, bad_strobe;
    logic [7:0] fc0;
    adv_cnt = 0; res_cnt = 0; vs_cnt = 0; bad = 0; bad_strobe = 0;
    mode    = 2'(m);
    density = 3'($urandom_range(0, 7));
    run_to_boundary(1'b1);
    fc0 = frame_cnt;
    for (int k = 0; k < FT; k++) begin
      rnd = 8'($urandom);
      step();
      if (vga_out !== exp_vga) begin
        bad++;
        if (bad < 5) $display("FAIL frame_pixel mode=%0d t=%0d got=%h want=%h", m, t, vga_out, exp_vga);
      end
      if (pif.rnd_advance !== model_adv(t, sh_mode) || pif.rnd_reseed !== model_reseed(t, sh_mode))
        bad_strobe++;
      if (pif.rnd_advance === 1'b1) adv_cnt++;
      if (pif.rnd_reseed === 1'b1) res_cnt++;
      if (!vga_out[3]) vs_cnt++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL frame_pixels mode=%0d bad=%0d want=0", m, bad); end
    n_cmp++;
    if (bad_strobe != 0) begin n_err++; $display("FAIL frame_strobes mode=%0d bad=%0d want=0", m, bad_strobe); end
    n_cmp++;
    if (adv_cnt != HA * VA) begin n_err++; $display("FAIL advance_count got=%0d want=%0d", adv_cnt, HA * VA); end
    n_cmp++;
    if (res_cnt != 1) begin n_err++; $display("FAIL reseed_count got=%0d want=1", res_cnt); end
    n_cmp++;
    if (vs_cnt != VS * HT) begin n_err++; $display("FAIL vsync_low_count got=%0d want=%0d", vs_cnt, VS * HT); end
    n_cmp++;
    if (frame_cnt !== fc0 + 8'd1) begin n_err++; $display("FAIL frame_cnt_step got=%h want=%h", frame_cnt, fc0 + 8'd1); end
  endtask

  typedef struct {
    logic [1:0] m;
    logic [2:0] d;
    logic [7:0] r;
    logic [7:0] e;
  } vec_t;

  task automatic test_directed_colours();
    vec_t vecs[5];
    int   bad;
    vecs[0] = '{m: 2'd0, d: 3'd0, r: 8'hFF, e: 8'hFF};
    vecs[1] = '{m: 2'd0, d: 3'd0, r: 8'hFE, e: 8'h88};
    vecs[2] = '{m: 2'd0, d: 3'd7, r: 8'h80, e: 8'hF8};
    vecs[3] = '{m: 2'd0, d: 3'd7, r: 8'h7F, e: 8'h88};
    vecs[4] = '{m: 2'd1, d: 3'd5, r: 8'h15, e: 8'hF8};
    foreach (vecs[i]) begin
      mode = vecs[i].m; density = vecs[i].d; rnd = vecs[i].r;
      run_to_boundary(1'b0);
      bad = 0;
      for (int k = 0; k < 2 * HT; k++) begin
        step();
        if (prev_active) begin
          if (vga_out !== vecs[i].e) begin
            bad++;
            if (bad < 3) $display("FAIL colour_%0d t=%0d got=%h want=%h", i, t, vga_out, vecs[i].e);
          end
        end else if ((vga_out & 8'h77) !== 8'h00) begin
          bad++;
          if (bad < 3) $display("FAIL blank_colour_%0d t=%0d got=%h want colour bits 0", i, t, vga_out);
        end
      end
      n_cmp++;
      if (bad != 0) begin n_err++; $display("FAIL directed_%0d bad=%0d want=0", i, bad); end
    end
  endtask

  task automatic test_noise_strobes();
    int bad_adv, bad_res, bad_pix;
    bad_adv = 0; bad_res = 0; bad_pix = 0;
    mode = 2'd1; density = 3'($urandom_range(0, 7));
    run_to_boundary(1'b1);
    for (int k = 0; k < FT; k++) begin
      rnd = 8'($urandom);
      step();
      if (pif.rnd_advance !== 1'b1) bad_adv++;
      if (pif.rnd_reseed !== 1'b0) bad_res++;
      if (vga_out !== exp_vga) bad_pix++;
    end
    n_cmp++;
    if (bad_adv != 0) begin n_err++; $display("FAIL noise_advance low_cycles=%0d want=0", bad_adv); end
    n_cmp++;
    if (bad_res != 0) begin n_err++; $display("FAIL noise_reseed high_cycles=%0d want=0", bad_res); end
    n_cmp++;
    if (bad_pix != 0) begin n_err++; $display("FAIL noise_pixels bad=%0d want=0", bad_pix); end
  endtask

  task automatic test_mode_change_mid_frame();
    int bad_rest, bad_next, lit;
    bad_rest = 0; bad_next = 0; lit = 0;
    mode = 2'd0; density = 3'd0; rnd = 8'hFF;
    run_to_boundary(1'b0);
    for (int i = 0; i < FT && (t % FT) != (VA / 2) * HT + HA / 2; i++) step();
    mode = 2'd3;
    density = 3'd7;
    for (int i = 0; i < FT && (t % FT) != 0; i++) begin
      step();
      if (prev_active) begin
        lit++;
        if (vga_out !== 8'hFF) bad_rest++;
      end else if (vga_out !== exp_vga) begin
        bad_rest++;
      end
    end
    for (int k = 0; k < FT; k++) begin
      step();
      if ((vga_out & 8'h77) !== 8'h00 || vga_out !== exp_vga) bad_next++;
    end
    n_cmp++;
    if (bad_rest != 0 || lit == 0) begin
      n_err++; $display("FAIL mode_hold_rest bad=%0d lit=%0d want bad=0", bad_rest, lit);
    end
    n_cmp++;
    if (bad_next != 0) begin n_err++; $display("FAIL mode_blank_next bad=%0d want=0", bad_next); end
  endtask

  task automatic test_twinkle();
    int bad;
    bad = 0;
    for (int f = 0; f < 2; f++) begin
      mode = 2'd2; density = 3'($urandom_range(4, 7));
      run_to_boundary(1'b1);
      for (int k = 0; k < FT / 2; k++) begin
        rnd = 8'($urandom);
        step();
        if (vga_out !== exp_vga) begin
          bad++;
          if (bad < 5) $display("FAIL twinkle_pixel t=%0d got=%h want=%h", t, vga_out, exp_vga);
        end
      end
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL twinkle bad=%0d want=0", bad); end
  endtask

  task automatic test_async_reset();
    int bad, first_fall;
    bad = 0; first_fall = -1;
    mode = 2'd0; density = 3'd7; rnd = 8'hFF;
    run_to_boundary(1'b0);
    for (int i = 0; i < FT && (t % FT) != 5 * HT + 20; i++) step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (vga_out !== 8'h88 || vga_out_full !== 8'h88) begin
      n_err++; $display("FAIL async_reset_vga got=%h/%h want=88", vga_out, vga_out_full);
    end
    n_cmp++;
    if (frame_cnt !== 8'h00 || pif.rnd_advance !== 1'b1 || pif.rnd_reseed !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_state fc=%h adv=%b res=%b want fc=00 adv=1 res=0",
               frame_cnt, pif.rnd_advance, pif.rnd_reseed);
    end
    release_reset();
    for (int k = 1; k <= 3 * HT; k++) begin
      rnd = 8'($urandom);
      step();
      if (vga_out !== exp_vga) bad++;
      if (first_fall < 0 && !vga_out[7]) first_fall = k;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL restart_pixels bad=%0d want=0", bad); end
    n_cmp++;
    if (first_fall != HA + HF + 1) begin
      n_err++; $display("FAIL restart_hsync_fall got=%0d want=%0d", first_fall, HA + HF + 1);
    end
  endtask

  initial begin
    test_reset();
    test_hsync_full();
    test_full_frame(0);
    test_full_frame(2);
    test_directed_colours();
    test_noise_strobes();
    test_mode_change_mid_frame();
    test_twinkle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
